// File: rtl/phy_mem_if.sv
// Bundle of request ports and memory-controller signals for phy_mem_master.
//   master : view taken by phy_mem_master. It receives the ifetch/data requests and
//            mem_data_out/mem_busy, and it drives the acks, read data, err and mem_*.
//   slave  : view taken by the requesters and the memory controller (the mirror of master).
interface phy_mem_if;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_ack;
  logic [31:0] ifetch_data;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        err;
  logic        mem_is_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_busy;

  modport master (
    input  ifetch_req, ifetch_addr, data_req, data_we, data_addr, data_wdata,
           mem_data_out, mem_busy,
    output ifetch_ack, ifetch_data, data_ack, data_rdata, err,
           mem_is_write, mem_addr, mem_data_in
  );

  modport slave (
    output ifetch_req, ifetch_addr, data_req, data_we, data_addr, data_wdata,
           mem_data_out, mem_busy,
    input  ifetch_ack, ifetch_data, data_ack, data_rdata, err,
           mem_is_write, mem_addr, mem_data_in
  );
endinterface

// File: rtl/phy_mem_master.sv
// phy_mem_master: arbitrates an instruction-fetch port and a data port onto a single
// physical memory controller. Misaligned or out-of-range accesses are rejected with err.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : phy_mem_if.master (request/ack ports plus the mem_* controller signals)
// All outputs are registered.
module phy_mem_master #(
  parameter int unsigned READ_SAMPLE_CYCLES = 2,
  parameter logic [31:0] RAM_ADDR_MASK      = 32'h001f_ffff
) (
  input logic       clk,
  input logic       rst,
  phy_mem_if.master bus
);

  localparam logic [7:0] CntLast = 8'(READ_SAMPLE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StRdWait, StWrIssue, StWrWait, StAck} state_e;

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        last_data_q;  // 1: the data port won the most recent grant
  logic        port_data_q;  // port that owns the current transaction

  logic        pick_data;
  logic        any_req;
  logic [31:0] g_addr;
  logic        g_we;
  logic        g_rej;
  logic        g_stall;

  // Round-robin choice plus the properties of the request that would be granted.
  always_comb begin
    any_req   = bus.ifetch_req || bus.data_req;
    pick_data = bus.data_req && (!bus.ifetch_req || !last_data_q);
    g_addr    = pick_data ? bus.data_addr : bus.ifetch_addr;
    g_we      = pick_data && bus.data_we;
    g_rej     = (g_addr[1:0] != 2'b00) || ((g_addr & RAM_ADDR_MASK) != g_addr);
    // A legal write may only be issued to an idle controller; hold off the whole grant.
    g_stall   = g_we && !g_rej && bus.mem_busy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= 8'd0;
      last_data_q      <= 1'b0;
      port_data_q      <= 1'b0;
      bus.ifetch_ack   <= 1'b0;
      bus.data_ack     <= 1'b0;
      bus.err          <= 1'b0;
      bus.mem_is_write <= 1'b0;
      bus.mem_addr     <= 32'd0;
      bus.mem_data_in  <= 32'd0;
      bus.ifetch_data  <= 32'd0;
      bus.data_rdata   <= 32'd0;
    end else begin
      // Pulse outputs default low; they are raised only on the edge entering their state.
      bus.ifetch_ack   <= 1'b0;
      bus.data_ack     <= 1'b0;
      bus.err          <= 1'b0;
      bus.mem_is_write <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req && !g_stall) begin
            last_data_q  <= pick_data;
            port_data_q  <= pick_data;
            bus.mem_addr <= g_addr;
            if (pick_data) bus.mem_data_in <= bus.data_wdata;
            cnt_q <= 8'd0;
            if (g_rej) begin
              state_q <= StAck;
              bus.err <= 1'b1;
              if (pick_data) begin
                bus.data_ack <= 1'b1;
                if (!g_we) bus.data_rdata <= 32'd0;
              end else begin
                bus.ifetch_ack  <= 1'b1;
                bus.ifetch_data <= 32'd0;
              end
            end else if (g_we) begin
              state_q          <= StWrIssue;
              bus.mem_is_write <= 1'b1;
            end else begin
              state_q <= StRdWait;
            end
          end
        end
        StRdWait: begin
          // Counter freezes while the controller is busy.
          if (!bus.mem_busy) begin
            if (cnt_q == CntLast) begin
              state_q <= StAck;
              if (port_data_q) begin
                bus.data_rdata <= bus.mem_data_out;
                bus.data_ack   <= 1'b1;
              end else begin
                bus.ifetch_data <= bus.mem_data_out;
                bus.ifetch_ack  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StWrIssue: begin
          state_q <= StWrWait;
        end
        StWrWait: begin
          // The first WR_WAIT cycle is skipped: the controller only raises busy on its
          // negedge update, so mem_busy is not yet trustworthy there.
          if (cnt_q == 8'd0) begin
            cnt_q <= 8'd1;
          end else if (!bus.mem_busy) begin
            state_q      <= StAck;
            bus.data_ack <= 1'b1;
          end
        end
        StAck: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
